mult_seq_via8: RTL and testbench



---
 rtl/mult_seq_via8.sv | 130 +++++++++++++
 tb/tb_mult_seq_via8.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_via8.sv
// mult_seq_via8: time-multiplexed WIDTH x WIDTH multiplier built around one 8x8 signed core.
// Operands are split into 7-bit digits. All digits are non-negative except the top one,
// which is a signed 8-bit digit. Each clock forms one digit-pair partial product and adds
// it, shifted into place, to a 2*EW-bit accumulator.
module mult_seq_via8 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_z,
    output logic                 o_busy
);

    localparam int unsigned NDIG = (WIDTH + 6) / 7;
    localparam int unsigned EW   = 7 * NDIG + 1;
    localparam int unsigned AW   = 2 * EW;
    localparam int unsigned CW   = $clog2(NDIG) + 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [EW-1:0]      a_q, a_d, b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      ja_q, ja_d, jb_q, jb_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic [7:0]         da_raw, db_raw, da, db;
    logic signed [15:0] pp;
    logic [AW-1:0]      pp_ext, pp_sh, acc_sum;
    int unsigned        ia, ib;
    logic               sa, sb;

    // Digit selection and one shifted partial product for the current (ja, jb) pair
    always_comb begin
        ia      = int'(ja_q);
        ib      = int'(jb_q);
        da_raw  = a_q[7*ia +: 8];
        db_raw  = b_q[7*ib +: 8];
        // Lower digits are 7-bit magnitudes; only the top digit carries the sign
        da      = (ja_q == LAST) ? da_raw : {1'b0, da_raw[6:0]};
        db      = (jb_q == LAST) ? db_raw : {1'b0, db_raw[6:0]};
        pp      = $signed(da) * $signed(db);
        pp_ext  = {{(AW-16){pp[15]}}, pp};
        pp_sh   = pp_ext << (7 * (ia + ib));
        acc_sum = acc_q + pp_sh;
    end

    // Next-state logic: accept in IDLE, iterate digit pairs in COMPUTE, hold in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ja_d    = ja_q;
        jb_d    = jb_q;
        z_d     = z_q;
        sa      = i_signed & i_a[WIDTH-1];
        sb      = i_signed & i_b[WIDTH-1];
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    a_d     = {{(EW-WIDTH){sa}}, i_a};
                    b_d     = {{(EW-WIDTH){sb}}, i_b};
                    acc_d   = '0;
                    ja_d    = '0;
                    jb_d    = '0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                acc_d = acc_sum;
                if (jb_q == LAST) begin
                    jb_d = '0;
                    if (ja_q == LAST) begin
                        ja_d    = '0;
                        z_d     = acc_sum[2*WIDTH-1:0];
                        state_d = ST_DONE;
                    end else begin
                        ja_d = ja_q + CW'(1);
                    end
                end else begin
                    jb_d = jb_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any in-flight product
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ja_q    <= '0;
            jb_q    <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ja_q    <= ja_d;
            jb_q    <= jb_d;
            z_q     <= z_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_busy  = (state_q != ST_IDLE);
    assign o_z     = z_q;

endmodule

// File: tb/tb_mult_seq_via8.sv
// Self-checking bench for mult_seq_via8 (WIDTH=16 main instance, WIDTH=8 secondary instance).
module tb_mult_seq_via8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, signed_m, rdy_in;
    logic [15:0] a, b;
    logic        ready, ovalid, busy;
    logic [31:0] z;

    logic        v8, s8, r8;
    logic [7:0]  a8, b8;
    logic        ready8, ovalid8, busy8;
    logic [15:0] z8;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];

    mult_seq_via8 #(.WIDTH(16)) dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready), .i_signed(signed_m),
        .i_a(a), .i_b(b), .o_valid(ovalid), .i_ready(rdy_in), .o_z(z), .o_busy(busy)
    );

    mult_seq_via8 #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(ready8), .i_signed(s8),
        .i_a(a8), .i_b(b8), .o_valid(ovalid8), .i_ready(r8), .o_z(z8), .o_busy(busy8)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] gold16(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
        logic [63:0] xe, ye, p;
        xe = {{48{s & x[15]}}, x};
        ye = {{48{s & y[15]}}, y};
        p  = xe * ye;
        return p[31:0];
    endfunction

    function automatic logic [15:0] gold8(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
        logic [31:0] xe, ye, p;
        xe = {{24{s & x[7]}}, x};
        ye = {{24{s & y[7]}}, y};
        p  = xe * ye;
        return p[15:0];
    endfunction

    // Drive one request into the idle 16-bit DUT and record its expected product
    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic s,
                        input logic [31:0] exp);
        @(negedge clk);
        a = xa; b = xb; signed_m = s; valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Count edges until o_valid; returns 100 on timeout
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!ovalid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_res();
        @(negedge clk);
        rdy_in = 1'b1;
        @(posedge clk); #1;
        rdy_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; rdy_in = 1'b0; signed_m = 1'b0; a = '0; b = '0;
        v8 = 1'b0; r8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;
        #2;
        checks++;
        if ({ready, ovalid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags16: got %b expected 100", {ready, ovalid, busy});
        end
        checks++;
        if (z !== 32'h0) begin
            failures++;
            $display("FAIL reset_z16: got %h expected 0", z);
        end
        checks++;
        if ({ready8, ovalid8, busy8, z8} !== {3'b100, 16'h0}) begin
            failures++;
            $display("FAIL reset_dut8: got %b/%h expected 100/0", {ready8, ovalid8, busy8}, z8);
        end
        #20;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_corners();
        logic [15:0] ta[4];
        logic [15:0] tb_[4];
        logic        ts[4];
        logic [31:0] te[4];
        logic [31:0] exp;
        int cyc;
        ta  = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        tb_ = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'd1234};
        ts  = '{1'b1, 1'b0, 1'b1, 1'b1};
        te  = '{32'h4000_0000, 32'hFFFE_0001, 32'h0000_0001, 32'hFFFF_FB2E};
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb_[i], ts[i], te[i]);
            wait_valid(cyc);
            checks++;
            if (cyc !== 9) begin
                failures++;
                $display("FAIL corner_latency[%0d]: got %0d expected 9", i, cyc);
            end
            exp = sb.pop_front();
            checks++;
            if (z !== exp) begin
                failures++;
                $display("FAIL corner_z[%0d]: got %h expected %h", i, z, exp);
            end
            release_res();
            checks++;
            if ({ready, ovalid} !== 2'b10) begin
                failures++;
                $display("FAIL corner_release[%0d]: got %b expected 10", i, {ready, ovalid});
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] exp;
        int bad;
        bad = 0;
        send(16'hFFFF, 16'd1234, 1'b1, 32'hFFFF_FB2E);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); signed_m = 1'($urandom); valid = k[0];
            @(posedge clk); #1;
            if (k < 9 && (ready !== 1'b0 || busy !== 1'b1 || ovalid !== 1'b0)) bad++;
        end
        valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL ignore_ready_low: got %0d bad cycles expected 0", bad);
        end
        exp = sb.pop_front();
        checks++;
        if (ovalid !== 1'b1 || z !== exp) begin
            failures++;
            $display("FAIL ignore_result: got valid=%b z=%h expected valid=1 z=%h", ovalid, z, exp);
        end
        release_res();
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int cyc, bad;
        bad = 0;
        send(16'd300, 16'd700, 1'b0, 32'd210000);
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL stall_latency: got %0d expected 9", cyc);
        end
        exp = sb.pop_front();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ovalid !== 1'b1 || z !== exp || ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        end
        release_res();
        checks++;
        if ({ready, ovalid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL stall_exit: got %b expected 100", {ready, ovalid, busy});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (z !== exp) begin
            failures++;
            $display("FAIL z_retained: got %h expected %h", z, exp);
        end
    endtask

    task automatic test_ready_early();
        logic [15:0] xa, xb;
        logic [31:0] exp;
        int cyc;
        xa = 16'($urandom); xb = 16'($urandom);
        rdy_in = 1'b1;
        send(xa, xb, 1'b1, gold16(xa, xb, 1'b1));
        wait_valid(cyc);
        checks++;
        if (cyc !== 9) begin
            failures++;
            $display("FAIL early_ready_latency: got %0d expected 9", cyc);
        end
        exp = sb.pop_front();
        checks++;
        if (z !== exp) begin
            failures++;
            $display("FAIL early_ready_z: got %h expected %h", z, exp);
        end
        @(posedge clk); #1;
        rdy_in = 1'b0;
        checks++;
        if ({ready, ovalid} !== 2'b10) begin
            failures++;
            $display("FAIL early_ready_exit: got %b expected 10", {ready, ovalid});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp, dropped;
        int cyc, bad;
        bad = 0;
        send(16'd12345, 16'd321, 1'b0, 32'd3962745);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        dropped = sb.pop_front();
        checks++;
        if ({ready, ovalid, busy} !== 3'b100 || z !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: got flags=%b z=%h expected flags=100 z=0 (dropped %h)",
                     {ready, ovalid, busy}, z, dropped);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ovalid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_no_pulse: got %0d bad cycles expected 0", bad);
        end
        send(16'h8001, 16'h7FFF, 1'b1, gold16(16'h8001, 16'h7FFF, 1'b1));
        wait_valid(cyc);
        exp = sb.pop_front();
        checks++;
        if (cyc !== 9 || z !== exp) begin
            failures++;
            $display("FAIL reset_recover: got lat=%0d z=%h expected lat=9 z=%h", cyc, z, exp);
        end
        release_res();
    endtask

    task automatic test_back_to_back();
        logic [15:0] xa, xb;
        logic        s;
        logic [31:0] exp;
        int cyc;
        for (int i = 0; i < 3; i++) begin
            xa = 16'($urandom); xb = 16'($urandom); s = 1'(i);
            send(xa, xb, s, gold16(xa, xb, s));
            wait_valid(cyc);
            exp = sb.pop_front();
            checks++;
            if (cyc !== 9 || z !== exp) begin
                failures++;
                $display("FAIL b2b[%0d]: got lat=%0d z=%h expected lat=9 z=%h", i, cyc, z, exp);
            end
            release_res();
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
    endtask

    task automatic test_random16();
        logic [15:0] xa, xb;
        logic        s;
        logic [31:0] exp;
        int cyc, lat_bad, z_bad;
        lat_bad = 0; z_bad = 0;
        for (int i = 0; i < 300; i++) begin
            xa = 16'($urandom); xb = 16'($urandom); s = 1'($urandom);
            if (i % 50 == 0) xa = 16'h8000;
            if (i % 70 == 0) xb = 16'hFFFF;
            send(xa, xb, s, gold16(xa, xb, s));
            wait_valid(cyc);
            exp = sb.pop_front();
            checks++;
            if (cyc !== 9) begin
                failures++; lat_bad++;
                if (lat_bad < 5) $display("FAIL rand16_latency: got %0d expected 9", cyc);
            end
            checks++;
            if (z !== exp) begin
                failures++; z_bad++;
                if (z_bad < 5)
                    $display("FAIL rand16_z: %h*%h s=%b got %h expected %h", xa, xb, s, z, exp);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            release_res();
        end
    endtask

    task automatic test_random8();
        logic [7:0]  xa, xb;
        logic        s;
        logic [15:0] exp;
        int cyc, bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            xa = 8'($urandom); xb = 8'($urandom); s = 1'($urandom);
            if (i == 0) begin xa = 8'h80; xb = 8'h80; s = 1'b1; end
            if (i == 1) begin xa = 8'hFF; xb = 8'hFF; s = 1'b0; end
            exp = gold8(xa, xb, s);
            @(negedge clk);
            a8 = xa; b8 = xb; s8 = s; v8 = 1'b1;
            @(posedge clk); #1;
            v8 = 1'b0;
            cyc = 0;
            while (!ovalid8 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            checks++;
            if (cyc !== 4 || z8 !== exp) begin
                failures++; bad++;
                if (bad < 5)
                    $display("FAIL rand8: %h*%h s=%b got lat=%0d z=%h expected lat=4 z=%h",
                             xa, xb, s, cyc, z8, exp);
            end
            @(negedge clk);
            r8 = 1'b1;
            @(posedge clk); #1;
            r8 = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_corners();
        test_ignore_busy();
        test_stall();
        test_ready_early();
        test_reset_mid();
        test_back_to_back();
        test_random16();
        test_random8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
